// File: rtl/atomic_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atomic_alu_pkg
// Description : Shared command-word width and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package atomic_alu_pkg;

    // Command word width, shared with the controller command port
    localparam int CMD_W = 12;

    // Playback state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/command_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : command_sequencer_if
// Description : Program-load / playback-control / command-issue bundle.
//               master = the agent loading and starting programs,
//               slave  = the command sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface command_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int CMD_W = atomic_alu_pkg::CMD_W
);
    localparam int c_addr_w = $clog2(DEPTH);

    logic                wr_en;
    logic [CMD_W-1:0]    wr_data;
    logic                clear;
    logic                start;
    logic                abort;
    logic [CMD_W-1:0]    command;
    logic                syscall;
    logic                busy;
    logic                done;
    logic                full;
    logic [c_addr_w:0]   prog_count;
    logic [c_addr_w-1:0] pc;

    modport master (
        output wr_en, wr_data, clear, start, abort,
        input  command, syscall, busy, done, full, prog_count, pc
    );

    modport slave (
        input  wr_en, wr_data, clear, start, abort,
        output command, syscall, busy, done, full, prog_count, pc
    );

endinterface
`default_nettype wire

// File: rtl/cmd_program_mem.sv
`default_nettype none
// ============================================================================
// Module      : cmd_program_mem
// Description : DEPTH x CMD_W program store. Synchronous write,
//               asynchronous read, contents survive reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_program_mem #(
    parameter int DEPTH = 16,
    parameter int CMD_W = 12
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [CMD_W-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [CMD_W-1:0]         o_rdata
);

    logic [CMD_W-1:0] r_mem [DEPTH];

    // Write port: one word per cycle, no reset so loaded programs persist
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : command_sequencer
// Description : Loads a short program of command words and replays it,
//               presenting each word with a one-cycle syscall strobe and
//               holding it for a fixed settle window.
// Revision    : 1.0 - initial release
// ============================================================================
module command_sequencer #(
    parameter int DEPTH       = 16,
    parameter int CMD_W       = atomic_alu_pkg::CMD_W,
    parameter int STEP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    command_sequencer_if.slave bus
);
    import atomic_alu_pkg::*;

    localparam int                  c_addr_w    = $clog2(DEPTH);
    localparam int                  c_cnt_w     = $clog2(STEP_CYCLES);
    localparam logic [c_cnt_w-1:0]  c_wait_load = c_cnt_w'(STEP_CYCLES - 2);
    localparam logic [c_addr_w:0]   c_depth     = (c_addr_w + 1)'(DEPTH);

    seq_state_t          r_state;
    logic [c_addr_w-1:0] r_pc;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_addr_w:0]   r_prog_count;
    logic [CMD_W-1:0]    r_command;
    logic                r_syscall;
    logic                r_busy;
    logic                r_done;

    logic                w_full;
    logic                w_loadable;
    logic                w_mem_we;
    logic                w_last;
    logic [c_addr_w-1:0] w_rd_addr;
    logic [CMD_W-1:0]    w_rd_data;

    assign w_full     = (r_prog_count == c_depth);
    assign w_loadable = (r_state == IDLE) || (r_state == DONE);
    // A write only lands when no higher-priority control is present
    assign w_mem_we   = w_loadable && bus.wr_en && !w_full && !bus.clear
                        && !bus.start && !bus.abort && !rst;
    assign w_last     = ({1'b0, r_pc} == (r_prog_count - 1'b1));
    // Starting reads word 0; stepping out of WAIT reads the next word
    assign w_rd_addr  = (r_state == WAIT) ? (r_pc + 1'b1) : '0;

    cmd_program_mem #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_prog_count[c_addr_w-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Playback FSM with registered command/strobe/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_cnt        <= '0;
            r_prog_count <= '0;
            r_command    <= '0;
            r_syscall    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (bus.abort) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_command <= '0;
            r_syscall <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.clear) begin
                        r_prog_count <= '0;
                        r_pc         <= '0;
                        r_state      <= IDLE;
                        r_done       <= 1'b0;
                        r_command    <= '0;
                    end else if (bus.start) begin
                        // start always consumes the cycle, so a coincident write is dropped
                        if (r_prog_count != '0) begin
                            r_pc      <= '0;
                            r_state   <= ISSUE;
                            r_command <= w_rd_data;
                            r_syscall <= 1'b1;
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                        end
                    end else if (bus.wr_en && !w_full) begin
                        r_prog_count <= r_prog_count + 1'b1;
                        r_state      <= IDLE;
                        r_done       <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_syscall <= 1'b0;
                    r_cnt     <= c_wait_load;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (w_last) begin
                            r_state   <= DONE;
                            r_command <= '0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_pc      <= r_pc + 1'b1;
                            r_command <= w_rd_data;
                            r_syscall <= 1'b1;
                            r_state   <= ISSUE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.command    = r_command;
    assign bus.syscall    = r_syscall;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.full       = w_full;
    assign bus.prog_count = r_prog_count;
    assign bus.pc         = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_command_sequencer
// Description : Directed self-checking bench for command_sequencer
//               (DEPTH=16, CMD_W=12, STEP_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_command_sequencer;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    command_sequencer_if #(.DEPTH(16), .CMD_W(12)) bus ();

    command_sequencer #(
        .DEPTH       (16),
        .CMD_W       (12),
        .STEP_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; observe 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [11:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests_run++;
        if (bus.command !== 12'h000 || bus.syscall !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got cmd=%h sys=%b busy=%b done=%b expected 000 0 0 0",
                     bus.command, bus.syscall, bus.busy, bus.done);
        end
        tests_run++;
        if (bus.prog_count !== 5'd0 || bus.pc !== 4'd0 || bus.full !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_counts: got prog_count=%0d pc=%0d full=%b expected 0 0 0",
                     bus.prog_count, bus.pc, bus.full);
        end
    endtask

    task automatic test_three_words();
        logic        exp_sys;
        logic        exp_done;
        logic        exp_busy;
        logic [11:0] exp_cmd;
        load_word(12'h101);
        load_word(12'h202);
        load_word(12'h303);
        tests_run++;
        if (bus.prog_count !== 5'd3) begin
            tests_failed++;
            $display("FAIL three_prog_count: got %0d expected 3", bus.prog_count);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            exp_sys  = (c == 1) || (c == 5) || (c == 9);
            exp_cmd  = (c <= 4) ? 12'h101 : (c <= 8) ? 12'h202 : (c <= 12) ? 12'h303 : 12'h000;
            exp_done = (c >= 13);
            exp_busy = (c <= 12);
            tests_run++;
            if (bus.syscall !== exp_sys) begin
                tests_failed++;
                $display("FAIL three_syscall t+%0d: got %b expected %b", c, bus.syscall, exp_sys);
            end
            tests_run++;
            if (bus.command !== exp_cmd) begin
                tests_failed++;
                $display("FAIL three_command t+%0d: got %h expected %h", c, bus.command, exp_cmd);
            end
            tests_run++;
            if (bus.done !== exp_done || bus.busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL three_status t+%0d: got done=%b busy=%b expected %b %b",
                         c, bus.done, bus.busy, exp_done, exp_busy);
            end
            step();
        end
    endtask

    task automatic test_full();
        int          pulses;
        logic        prev_sys;
        logic [11:0] last_cmd;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        tests_run++;
        if (bus.prog_count !== 5'd0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_clear: got prog_count=%0d done=%b expected 0 0", bus.prog_count, bus.done);
        end
        for (int i = 0; i < 16; i++) begin
            load_word(12'(i));
        end
        tests_run++;
        if (bus.full !== 1'b1 || bus.prog_count !== 5'd16) begin
            tests_failed++;
            $display("FAIL full_flag: got full=%b prog_count=%0d expected 1 16", bus.full, bus.prog_count);
        end
        load_word(12'hABC);
        tests_run++;
        if (bus.prog_count !== 5'd16) begin
            tests_failed++;
            $display("FAIL full_overflow: got prog_count=%0d expected 16", bus.prog_count);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        pulses   = 0;
        prev_sys = 1'b0;
        last_cmd = 12'h000;
        for (int c = 1; c <= 70; c++) begin
            if (bus.syscall === 1'b1) begin
                tests_run++;
                if (bus.command !== 12'(pulses)) begin
                    tests_failed++;
                    $display("FAIL full_word %0d: got %h expected %h", pulses, bus.command, 12'(pulses));
                end
                pulses++;
                last_cmd = bus.command;
            end
            tests_run++;
            if (prev_sys === 1'b1 && bus.syscall === 1'b1) begin
                tests_failed++;
                $display("FAIL full_adjacent t+%0d: got two consecutive syscalls expected gap", c);
            end
            prev_sys = bus.syscall;
            if (c == 65) begin
                tests_run++;
                if (bus.done !== 1'b1 || bus.pc !== 4'd15) begin
                    tests_failed++;
                    $display("FAIL full_done: got done=%b pc=%0d expected 1 15", bus.done, bus.pc);
                end
            end
            step();
        end
        tests_run++;
        if (pulses != 16 || last_cmd !== 12'h00F) begin
            tests_failed++;
            $display("FAIL full_playback: got pulses=%0d last=%h expected 16 00f", pulses, last_cmd);
        end
    endtask

    task automatic test_empty_start();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tests_run++;
            if (bus.syscall !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_start t+%0d: got sys=%b busy=%b expected 0 0", c, bus.syscall, bus.busy);
            end
            step();
        end
        tests_run++;
        if (bus.done !== 1'b0 || bus.prog_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL empty_state: got done=%b prog_count=%0d expected 0 0", bus.done, bus.prog_count);
        end
    endtask

    task automatic test_abort();
        logic [11:0] exp_words [4];
        int          pulses;
        exp_words[0] = 12'h011;
        exp_words[1] = 12'h022;
        exp_words[2] = 12'h033;
        exp_words[3] = 12'h044;
        for (int i = 0; i < 4; i++) begin
            load_word(exp_words[i]);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        step();
        tests_run++;
        if (bus.syscall !== 1'b1 || bus.command !== 12'h022) begin
            tests_failed++;
            $display("FAIL abort_second_pulse: got sys=%b cmd=%h expected 1 022", bus.syscall, bus.command);
        end
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.syscall !== 1'b0 || bus.pc !== 4'd0 || bus.command !== 12'h000) begin
            tests_failed++;
            $display("FAIL abort_state: got busy=%b sys=%b pc=%0d cmd=%h expected 0 0 0 000",
                     bus.busy, bus.syscall, bus.pc, bus.command);
        end
        tests_run++;
        if (bus.prog_count !== 5'd4) begin
            tests_failed++;
            $display("FAIL abort_program: got prog_count=%0d expected 4", bus.prog_count);
        end
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.syscall === 1'b1) pulses++;
            step();
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulses);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 18; c++) begin
            if (bus.syscall === 1'b1) begin
                tests_run++;
                if (pulses > 3 || bus.command !== exp_words[pulses[1:0]]) begin
                    tests_failed++;
                    $display("FAIL abort_replay word %0d: got %h expected %h",
                             pulses, bus.command, exp_words[pulses[1:0]]);
                end
                pulses++;
            end
            step();
        end
        tests_run++;
        if (pulses != 4 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_replay_end: got pulses=%0d done=%b expected 4 1", pulses, bus.done);
        end
    endtask

    task automatic test_clear_start_conflicts();
        int pulses;
        bus.clear = 1'b1;
        bus.start = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        tests_run++;
        if (bus.prog_count !== 5'd0 || bus.syscall !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_start: got prog_count=%0d sys=%b busy=%b done=%b expected 0 0 0 0",
                     bus.prog_count, bus.syscall, bus.busy, bus.done);
        end
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.syscall === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL clear_start_pulse: got %0d pulses expected 0", pulses);
        end
        load_word(12'h055);
        load_word(12'h066);
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 12'h777;
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        tests_run++;
        if (bus.prog_count !== 5'd2 || bus.syscall !== 1'b1 || bus.command !== 12'h055) begin
            tests_failed++;
            $display("FAIL start_write: got prog_count=%0d sys=%b cmd=%h expected 2 1 055",
                     bus.prog_count, bus.syscall, bus.command);
        end
        pulses = 1;
        for (int c = 2; c <= 10; c++) begin
            step();
            if (bus.syscall === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 2 || bus.done !== 1'b1 || bus.prog_count !== 5'd2) begin
            tests_failed++;
            $display("FAIL start_write_run: got pulses=%0d done=%b prog_count=%0d expected 2 1 2",
                     pulses, bus.done, bus.prog_count);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 5; c++) step();
        tests_run++;
        if (bus.command !== 12'h066 || bus.syscall !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got cmd=%h sys=%b busy=%b expected 066 0 1",
                     bus.command, bus.syscall, bus.busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (bus.command !== 12'h000 || bus.syscall !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got cmd=%h sys=%b busy=%b done=%b expected 000 0 0 0",
                     bus.command, bus.syscall, bus.busy, bus.done);
        end
        tests_run++;
        if (bus.prog_count !== 5'd0 || bus.pc !== 4'd0 || bus.full !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_counts: got prog_count=%0d pc=%0d full=%b expected 0 0 0",
                     bus.prog_count, bus.pc, bus.full);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.syscall === 1'b1) pulses++;
            step();
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet: got %0d pulses expected 0", pulses);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 12'h000;
        bus.clear    = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        test_reset();
        test_three_words();
        test_full();
        test_empty_start();
        test_abort();
        test_clear_start_conflicts();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/command_sequencer.md
Name: command_sequencer

Overview:
Issuer side of the 12-bit command / run interface consumed by the datapath top (controller `command` and `syscall`/`run` inputs).
- Holds a small program of command words loaded one per cycle.
- On `start`, replays the program in order: each word is presented on `command` with a one-cycle `syscall` pulse, then held for a fixed settle window.
- Replaces manual switch-and-button entry for scripted ALU sequences and self-test.

Parameters:
- DEPTH, 16: program capacity in command words. Power of two, at least 2.
- CMD_W, 12: command word width. Must match the controller command port.
- STEP_CYCLES, 4: cycles per issued command, counting the syscall cycle. At least 2.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- wr_en, input, 1: append `wr_data` to the program.
- wr_data, input, CMD_W: command word to append.
- clear, input, 1: empty the program (`prog_count` set to 0).
- start, input, 1: begin playback from word 0.
- abort, input, 1: stop playback immediately.
- command, output, CMD_W: command word to the controller.
- syscall, output, 1: one-cycle run strobe to the controller.
- busy, output, 1: high in ISSUE or WAIT.
- done, output, 1: high in DONE.
- full, output, 1: `prog_count == DEPTH`.
- prog_count, output, $clog2(DEPTH)+1: number of words loaded.
- pc, output, $clog2(DEPTH): index of the word currently issued.

Behaviour:
- Reset (`rst` high at a clock edge):
  - state IDLE.
  - `command`=0, `syscall`=0, `busy`=0, `done`=0, `prog_count`=0, `pc`=0, wait counter 0.
  - Memory contents are not cleared.
- States: IDLE, ISSUE, WAIT, DONE.
- Load (IDLE or DONE only):
  - `wr_en` with `!full`: `mem[prog_count] <= wr_data`, `prog_count` increments. In DONE this also moves the state to IDLE.
  - `wr_en` while `full`, or while `busy`: ignored, no state change.
  - `clear` (IDLE or DONE): `prog_count` <= 0, state <= IDLE. Ignored while `busy`.
- Start (IDLE or DONE):
  - `start` with `prog_count > 0`: `pc` <= 0, go to ISSUE.
  - `start` with `prog_count == 0`: ignored.
- ISSUE (1 cycle):
  - `command = mem[pc]`, `syscall` = 1.
  - Next state WAIT; wait counter loads STEP_CYCLES-2.
- WAIT:
  - `command` holds `mem[pc]`, `syscall` = 0; counter decrements.
  - When counter = 0:
    - if `pc == prog_count-1`, go to DONE;
    - else `pc++` and go to ISSUE.
- Timing: with `start` sampled at edge t:
  - syscall for word k is high in cycle t+1+k*STEP_CYCLES;
  - DONE is entered at t+1+N*STEP_CYCLES.
  - Exactly N syscall pulses, never two adjacent.
- DONE: `done` = 1, `command` = 0, `pc` holds the last index. Leave on `start`, `clear` or `wr_en`.
- `command` = 0 whenever the state is IDLE or DONE.
- Priorities, highest first: `rst` > `abort` > `clear` > `start` > `wr_en`.
  - `abort` in any state: next state IDLE, `syscall` 0, `pc` 0, program retained.
  - A `syscall` already driven in the current cycle completes; no further pulses are issued.
  - `start` and `wr_en` in the same cycle: the write is dropped.
- Reset during playback: identical to power-on reset; `prog_count` returns to 0.
- `pc` never exceeds `prog_count-1`. A full program (DEPTH words) issues all DEPTH words with no wrap-around.

Decomposition:
- Package `atomic_alu_pkg`:
  - `CMD_W` constant, shared with the controller;
  - `seq_state_t` enum {IDLE, ISSUE, WAIT, DONE}.
- One sub-module `cmd_program_mem`: DEPTH x CMD_W, synchronous write, asynchronous read, no reset.
- FSM, counters and output logic stay in `command_sequencer`.

Test Plan:
- Reset, then load 3'h: 12'h101, 12'h202, 12'h303, then `start` at edge t → `syscall` high only at t+1, t+5, t+9. `command` = 12'h101 / 12'h202 / 12'h303 during those windows. `done` = 1 from t+13.
- Load 16 words 12'h000..12'h00F → `full` = 1, `prog_count` = 16. A 17th `wr_en` leaves `prog_count` = 16 and word 15 unchanged. Playback issues 16 pulses, last `command` = 12'h00F.
- `start` with an empty program → state stays IDLE, `syscall` never asserts, `busy` = 0.
- Load 4 words, start, assert `abort` in the cycle after the second syscall → no third pulse, `busy` = 0 next cycle, `pc` = 0. Restarting replays all 4 words.
- `clear`+`start` together in DONE → `prog_count` = 0, IDLE, no pulse. `start`+`wr_en` together → write dropped, `prog_count` unchanged.
- Assert `rst` in WAIT of word 1 → next cycle all outputs at reset values and `prog_count` = 0. No `syscall` for the rest of the run.
